// File: rtl/ap_host_ctrl_pkg.sv
// ap_host_ctrl_pkg: shared AP command, column, error and FSM state definitions
package ap_host_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_OR  = 3'd0,
    CMD_XOR = 3'd1,
    CMD_AND = 3'd2,
    CMD_NOT = 3'd3,
    CMD_ADD = 3'd4,
    CMD_SUB = 3'd5,
    CMD_MUL = 3'd6
  } ap_cmd_e;

  typedef enum logic [1:0] {
    COL_A = 2'd0,
    COL_B = 2'd1,
    COL_C = 2'd2
  } ap_col_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_CMD     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } ap_err_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WR_A,
    ST_WR_B,
    ST_START,
    ST_WAIT_IRQ,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_FIN
  } ap_state_e;

  // Codes above MUL have no AP meaning and are rejected without touching the AP.
  function automatic logic cmd_ok(input logic [2:0] c);
    return c <= 3'(CMD_MUL);
  endfunction

endpackage

// File: rtl/ap_host_ctrl.sv
// ap_host_ctrl: streams operand pairs into the AP, runs one command, reads results back
module ap_host_ctrl
  import ap_host_ctrl_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_W     = 9,
  parameter int CELL_QUANT = 512,
  parameter int RD_LAT     = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [2:0]           job_cmd,
  input  logic [ADDR_W:0]      job_len,
  input  logic                 opnd_valid,
  output logic                 opnd_ready,
  input  logic [WORD_SIZE-1:0] opnd_a,
  input  logic [WORD_SIZE-1:0] opnd_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] res_data,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_wdata,
  output logic                 ap_mode,
  output logic                 ap_op_direction,
  output logic [2:0]           ap_cmd,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_sel_internal_col,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  input  logic [WORD_SIZE-1:0] ap_rdata,
  input  logic                 ap_irq
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(CELL_QUANT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(RD_LAT - 2);

  ap_state_e            r_state, w_state;
  ap_err_e              r_err, w_err;
  logic [2:0]           r_cmd, w_cmd;
  logic [ADDR_W:0]      r_len, w_len;
  logic [ADDR_W:0]      r_cnt, w_cnt;
  logic [WAIT_W-1:0]    r_wait, w_wait;
  logic [WORD_SIZE-1:0] r_a, w_a;
  logic [WORD_SIZE-1:0] r_b, w_b;
  logic [WORD_SIZE-1:0] r_res, w_res;
  logic [ADDR_W:0]      w_cnt_inc;
  logic [ADDR_W:0]      w_len_clamp;
  logic                 w_more;

  assign w_cnt_inc           = r_cnt + 1'b1;
  assign w_more              = w_cnt_inc < r_len;
  assign w_len_clamp         = (job_len > LEN_MAX) ? LEN_MAX : job_len;
  assign busy                = r_state != ST_IDLE;
  assign res_data            = r_res;
  assign ap_addr             = r_cnt[ADDR_W-1:0];
  assign ap_op_direction     = 1'b0;
  assign ap_sel_internal_col = 1'b0;

  // Next-state and output decode; one cell counter serves both the load and the readback phase.
  always_comb begin
    w_state     = r_state;
    w_err       = r_err;
    w_cmd       = r_cmd;
    w_len       = r_len;
    w_cnt       = r_cnt;
    w_wait      = r_wait;
    w_a         = r_a;
    w_b         = r_b;
    w_res       = r_res;
    job_ready   = 1'b0;
    opnd_ready  = 1'b0;
    res_valid   = 1'b0;
    done        = 1'b0;
    err         = 2'(ERR_OK);
    ap_mode     = 1'b0;
    ap_cmd      = 3'd0;
    ap_sel_col  = 2'(COL_A);
    ap_wdata    = '0;
    ap_write_en = 1'b0;
    ap_read_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        job_ready = !rst;
        if (job_valid && !rst) begin
          w_cmd   = job_cmd;
          w_len   = w_len_clamp;
          w_cnt   = '0;
          w_err   = cmd_ok(job_cmd) ? ERR_OK : ERR_CMD;
          w_state = (!cmd_ok(job_cmd) || job_len == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        opnd_ready = 1'b1;
        if (opnd_valid) begin
          w_a     = opnd_a;
          w_b     = opnd_b;
          w_state = ST_WR_A;
        end
      end
      ST_WR_A: begin
        ap_write_en = 1'b1;
        ap_wdata    = r_a;
        w_state     = ST_WR_B;
      end
      ST_WR_B: begin
        ap_write_en = 1'b1;
        ap_sel_col  = 2'(COL_B);
        ap_wdata    = r_b;
        w_cnt       = w_cnt_inc;
        w_state     = w_more ? ST_LOAD : ST_START;
      end
      ST_START: begin
        ap_mode = 1'b1;
        ap_cmd  = r_cmd;
        w_wait  = '0;
        w_state = ST_WAIT_IRQ;
      end
      ST_WAIT_IRQ: begin
        ap_mode = 1'b1;
        ap_cmd  = r_cmd;
        if (ap_irq) begin
          w_cnt   = '0;
          w_state = ST_RD_ISSUE;
        end else if (r_wait == WAIT_LAST) begin
          w_err   = ERR_TIMEOUT;
          w_state = ST_FIN;
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end
      ST_RD_ISSUE: begin
        ap_read_en = 1'b1;
        ap_sel_col = 2'(COL_C);
        w_wait     = '0;
        w_state    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (r_wait == LAT_LAST) begin
          w_res   = ap_rdata;
          w_state = ST_RD_HOLD;
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end
      ST_RD_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_cnt   = w_cnt_inc;
          w_state = w_more ? ST_RD_ISSUE : ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = 2'(r_err);
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_err   <= ERR_OK;
      r_cmd   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state;
      r_err   <= w_err;
      r_cmd   <= w_cmd;
      r_len   <= w_len;
      r_cnt   <= w_cnt;
      r_wait  <= w_wait;
      r_a     <= w_a;
      r_b     <= w_b;
      r_res   <= w_res;
    end
  end

endmodule

// File: tb/tb_ap_host_ctrl.sv
// tb_ap_host_ctrl: directed checks of ap_host_ctrl against a behavioural AP responder
module tb_ap_host_ctrl;
  localparam int AW = 9;
  localparam int CQ = 512;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [2:0]    job_cmd = '0;
  logic [AW:0]   job_len = '0;
  logic          opnd_valid = 1'b0;
  logic          opnd_ready;
  logic [7:0]    opnd_a = '0;
  logic [7:0]    opnd_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [7:0]    res_data;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic [AW-1:0] ap_addr;
  logic [7:0]    ap_wdata;
  logic          ap_mode;
  logic          ap_op_direction;
  logic [2:0]    ap_cmd;
  logic [1:0]    ap_sel_col;
  logic          ap_sel_internal_col;
  logic          ap_write_en;
  logic          ap_read_en;
  logic [7:0]    ap_rdata = '0;
  logic          ap_irq = 1'b0;
  logic [41:0]   outs;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] mem_a[CQ];
  logic [7:0] mem_b[CQ];
  logic [7:0] mem_c[CQ];
  logic [7:0] op_a[600];
  logic [7:0] op_b[600];
  logic [7:0] res_q[$];
  int n_wr = 0, n_rd = 0, n_cmp = 0, viol = 0, mode_len = 0, irq_delay = 3;
  bit mode_prev = 0, irq_on = 1, force_irq = 0;

  ap_host_ctrl #(
    .WORD_SIZE(8), .ADDR_W(AW), .CELL_QUANT(CQ), .RD_LAT(2), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_cmd(job_cmd), .job_len(job_len),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err(err),
    .ap_addr(ap_addr), .ap_wdata(ap_wdata), .ap_mode(ap_mode), .ap_op_direction(ap_op_direction),
    .ap_cmd(ap_cmd), .ap_sel_col(ap_sel_col), .ap_sel_internal_col(ap_sel_internal_col),
    .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_rdata(ap_rdata), .ap_irq(ap_irq)
  );

  assign outs = {job_ready, opnd_ready, res_valid, res_data, busy, done, err, ap_mode,
                 ap_op_direction, ap_sel_internal_col, ap_write_en, ap_read_en,
                 ap_addr, ap_wdata, ap_cmd, ap_sel_col};

  always #5 clock = ~clock;

  function automatic logic [7:0] ap_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      3'd0: return a | b;
      3'd1: return a ^ b;
      3'd2: return a & b;
      3'd3: return ~a;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return a * b;
      default: return 8'hxx;
    endcase
  endfunction

  // AP responder: column storage, whole-array compute on the rising edge of ap_mode, registered reads.
  always @(negedge clock) begin
    if ((ap_write_en || ap_read_en) && ap_mode) viol++;
    if (ap_write_en) begin
      n_wr++;
      if (ap_sel_col == 2'd0) mem_a[ap_addr] = ap_wdata;
      else mem_b[ap_addr] = ap_wdata;
    end
    if (ap_read_en) begin
      n_rd++;
      ap_rdata = mem_c[ap_addr];
    end
    if (ap_mode) begin
      if (!mode_prev) begin
        n_cmp++;
        mode_len = 0;
        for (int i = 0; i < CQ; i++) mem_c[i] = ap_op(ap_cmd, mem_a[i], mem_b[i]);
      end
      mode_len++;
    end
    mode_prev = ap_mode;
    ap_irq = force_irq || (irq_on && ap_mode && mode_len == irq_delay);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one job cycle by cycle; abort=1 asserts rst in WR_B, abort=2 in the first WAIT_IRQ cycle.
  task automatic run_job(input logic [2:0] cmd, input logic [AW:0] len, input int n_ops,
                         input int stall, input int abort, input int max_cyc,
                         output bit got_done, output logic [1:0] e, output int lat, output bit stall_ok);
    int idx, k_hs, stall_left, r0;
    bit jh, oh, rh, seen_stall, prev_mode;
    logic [7:0] d0;
    logic [AW-1:0] a0;
    idx = 0; k_hs = 0; got_done = 0; e = 2'bxx; lat = -1; stall_ok = 1;
    stall_left = stall; seen_stall = 0; prev_mode = 0; r0 = 0; d0 = '0; a0 = '0;
    res_q.delete();
    job_valid = 1'b1; job_cmd = cmd; job_len = len;
    for (int k = 0; k < max_cyc; k++) begin
      opnd_valid = idx < n_ops;
      opnd_a = op_a[idx];
      opnd_b = op_b[idx];
      if (res_valid && stall_left > 0) begin
        res_ready = 1'b0;
        if (!seen_stall) begin
          seen_stall = 1; d0 = res_data; a0 = ap_addr; r0 = n_rd;
        end else if (res_data !== d0 || ap_addr !== a0 || n_rd != r0 || ap_read_en !== 1'b0) begin
          stall_ok = 0;
        end
        stall_left--;
      end else begin
        res_ready = 1'b1;
      end
      jh = job_valid && job_ready;
      oh = opnd_valid && opnd_ready;
      rh = res_valid && res_ready;
      if (jh) k_hs = k;
      if (rh) res_q.push_back(res_data);
      if (done) begin
        got_done = 1; e = err; lat = k - k_hs;
        break;
      end
      if ((abort == 1 && ap_write_en && ap_sel_col == 2'd1) || (abort == 2 && ap_mode && prev_mode)) begin
        rst = 1'b1;
        break;
      end
      prev_mode = ap_mode;
      @(posedge clock); #1;
      if (jh) job_valid = 1'b0;
      if (oh) idx++;
    end
    job_valid = 1'b0; opnd_valid = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    bit gd, sok;
    logic [1:0] e;
    int lat, w0, r0, c0;
    for (int i = 0; i < CQ; i++) begin mem_a[i] = '0; mem_b[i] = '0; mem_c[i] = '0; end
    for (int i = 0; i < 600; i++) begin op_a[i] = '0; op_b[i] = '0; end

    repeat (2) begin @(posedge clock); #1; end
    chk("reset_outs", 64'(outs), 64'd0);
    rst = 1'b0; #1;
    chk("ready_after_reset", 64'(job_ready), 64'd1);

    force_irq = 1;
    repeat (3) begin @(posedge clock); #1; end
    chk("irq_ignored_idle", 64'({busy, opnd_ready, done}), 64'd0);
    force_irq = 0;
    @(posedge clock); #1;

    op_a[0] = 8'd1;   op_b[0] = 8'd2;
    op_a[1] = 8'd200; op_b[1] = 8'd100;
    op_a[2] = 8'd255; op_b[2] = 8'd1;
    w0 = n_wr; r0 = n_rd; c0 = n_cmp;
    irq_on = 1; irq_delay = 3;
    run_job(3'd4, 10'd3, 3, 0, 0, 100, gd, e, lat, sok);
    chk("add_done", 64'(gd), 64'd1);
    chk("add_err", 64'(e), 64'd0);
    chk("add_latency", 64'(lat), 64'd22);
    chk("add_nres", 64'(res_q.size()), 64'd3);
    chk("add_res", 64'({res_q[0], res_q[1], res_q[2]}), 64'({8'd3, 8'd44, 8'd0}));
    chk("add_col_a", 64'({mem_a[0], mem_a[1], mem_a[2]}), 64'({8'd1, 8'd200, 8'd255}));
    chk("add_col_b", 64'({mem_b[0], mem_b[1], mem_b[2]}), 64'({8'd2, 8'd100, 8'd1}));
    chk("add_traffic", 64'({16'(n_wr - w0), 16'(n_rd - r0), 16'(n_cmp - c0)}), 64'({16'd6, 16'd3, 16'd1}));
    @(posedge clock); #1;

    w0 = n_wr; r0 = n_rd; c0 = n_cmp;
    run_job(3'd7, 10'd4, 4, 0, 0, 20, gd, e, lat, sok);
    chk("badcmd_done", 64'(gd), 64'd1);
    chk("badcmd_err", 64'(e), 64'd1);
    chk("badcmd_latency", 64'(lat >= 1 && lat <= 2), 64'd1);
    chk("badcmd_traffic", 64'({16'(n_wr - w0), 16'(n_rd - r0), 16'(n_cmp - c0)}), 64'd0);
    @(posedge clock); #1;

    w0 = n_wr; r0 = n_rd; c0 = n_cmp;
    run_job(3'd1, 10'd0, 0, 0, 0, 20, gd, e, lat, sok);
    chk("len0_done_err", 64'({gd, e}), 64'({1'b1, 2'd0}));
    chk("len0_traffic", 64'({16'(n_wr - w0), 16'(n_rd - r0), 16'(n_cmp - c0)}), 64'd0);
    @(posedge clock); #1;

    op_a[0] = 8'd5; op_b[0] = 8'd6;
    r0 = n_rd;
    irq_on = 0;
    run_job(3'd4, 10'd1, 1, 0, 0, 100, gd, e, lat, sok);
    chk("timeout_done_err", 64'({gd, e}), 64'({1'b1, 2'd2}));
    chk("timeout_mode_cycles", 64'(mode_len), 64'(TO + 1));
    chk("timeout_latency", 64'(lat), 64'd21);
    chk("timeout_no_reads", 64'(n_rd - r0), 64'd0);
    @(posedge clock); #1;

    irq_on = 1; irq_delay = TO + 1;
    run_job(3'd4, 10'd1, 1, 0, 0, 100, gd, e, lat, sok);
    chk("irq_at_expiry_err", 64'({gd, e}), 64'({1'b1, 2'd0}));
    chk("irq_at_expiry_mode", 64'(mode_len), 64'(TO + 1));
    chk("irq_at_expiry_res", 64'(res_q[0]), 64'd11);
    irq_delay = 3;
    @(posedge clock); #1;

    op_a[0] = 8'd10; op_b[0] = 8'd3;
    op_a[1] = 8'd0;  op_b[1] = 8'd1;
    r0 = n_rd;
    run_job(3'd5, 10'd2, 2, 10, 0, 100, gd, e, lat, sok);
    chk("stall_stable", 64'(sok), 64'd1);
    chk("stall_res", 64'({gd, e, res_q[0], res_q[1]}), 64'({1'b1, 2'd0, 8'd7, 8'd255}));
    chk("stall_reads", 64'(n_rd - r0), 64'd2);
    @(posedge clock); #1;

    run_job(3'd4, 10'd2, 2, 0, 1, 100, gd, e, lat, sok);
    @(posedge clock); #1;
    chk("rst_in_wrb_outs", 64'(outs), 64'd0);
    rst = 1'b0; #1;
    chk("rst_in_wrb_ready", 64'(job_ready), 64'd1);
    irq_on = 0;
    run_job(3'd4, 10'd2, 2, 0, 2, 100, gd, e, lat, sok);
    @(posedge clock); #1;
    chk("rst_in_wait_outs", 64'(outs), 64'd0);
    rst = 1'b0; #1;
    chk("rst_in_wait_ready", 64'(job_ready), 64'd1);
    irq_on = 1;
    op_a[0] = 8'd7; op_b[0] = 8'd9;
    run_job(3'd6, 10'd1, 1, 0, 0, 100, gd, e, lat, sok);
    chk("after_rst_job", 64'({gd, e, 8'(res_q.size()), res_q[0]}), 64'({1'b1, 2'd0, 8'd1, 8'd63}));
    @(posedge clock); #1;

    for (int i = 0; i < 517; i++) begin op_a[i] = 8'(i); op_b[i] = 8'h5A; end
    w0 = n_wr; r0 = n_rd;
    run_job(3'd1, 10'(CQ + 5), 517, 0, 0, 4000, gd, e, lat, sok);
    chk("clamp_done_err", 64'({gd, e}), 64'({1'b1, 2'd0}));
    chk("clamp_nres", 64'(res_q.size()), 64'(CQ));
    chk("clamp_traffic", 64'({32'(n_wr - w0), 32'(n_rd - r0)}), 64'({32'(2 * CQ), 32'(CQ)}));
    chk("clamp_res", 64'({res_q[0], res_q[300], res_q[511]}), 64'({8'h5A, 8'h76, 8'hA5}));

    chk("no_io_during_mode", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
